gptp_tx_sched: RTL and testbench

- Round-robin scheduler that shares one gPTP tx timestamp logic instance among N transmit-buffer requesters.
- Accepts one request at a time (buffer address + 80-bit timestamp word) and drives it onto the shared send_* interface.
- Waits for the write-back on send_r_vaild/send_r_data and routes it to the originating requester.
- A watchdog aborts a transaction whose write-back never arrives.

---
 rtl/gptp_tx_sched.sv | 141 ++++++++++++++
 tb/tb_gptp_tx_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gptp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : gptp_tx_sched
// Brief    : Round-robin scheduler sharing one gPTP tx timestamp engine among
//            N transmit-buffer requesters. Issues one request at a time,
//            waits for the write-back, routes it to the owner, and aborts
//            transactions whose write-back never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module gptp_tx_sched #(
    parameter int N       = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 80,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_vaild,
    output logic [N-1:0]        req_ready,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_data,
    output logic [N-1:0]        resp_vaild,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_timeout,
    output logic [ADDR_W-1:0]   send_addr,
    output logic                send_vaild,
    input  logic                send_ready,
    output logic [DATA_W-1:0]   send_data,
    input  logic                send_r_vaild,
    input  logic [DATA_W-1:0]   send_r_data,
    output logic                busy,
    output logic [7:0]          timeout_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Timer value on the last WAIT cycle before an abort is declared.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [15:0]      timer;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             accept;

    // Round-robin arbitration: first requester after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (!win_found && req_vaild[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Accept only in IDLE, and never while reset is held so all outputs stay 0.
    always_comb begin
        accept    = (state == S_IDLE) && win_found && reset;
        req_ready = accept ? (N'(1) << win_idx) : '0;
        busy      = (state != S_IDLE);
    end

    // Transaction FSM: latch request, handshake with tx logic, return write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            last         <= IDX_W'(N - 1);
            owner        <= '0;
            timer        <= '0;
            send_addr    <= '0;
            send_data    <= '0;
            send_vaild   <= 1'b0;
            resp_vaild   <= '0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
            timeout_cnt  <= '0;
        end else begin
            // Responses are single-cycle pulses; data/flag are zero when idle.
            resp_vaild   <= '0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        send_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        send_data  <= req_data[win_idx*DATA_W +: DATA_W];
                        owner      <= win_idx;
                        last       <= win_idx;
                        send_vaild <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Write-backs arriving here are stale and intentionally ignored.
                    if (send_ready) begin
                        send_vaild <= 1'b0;
                        timer      <= '0;
                        state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    timer <= timer + 16'd1;
                    // A write-back on the terminal timer cycle beats the abort.
                    if (send_r_vaild) begin
                        resp_vaild <= N'(1) << owner;
                        resp_data  <= send_r_data;
                        state      <= S_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        resp_vaild   <= N'(1) << owner;
                        resp_timeout <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gptp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_gptp_tx_sched
// Brief    : Self-checking bench for gptp_tx_sched with a transaction-level
//            reference model (round-robin pick, saturating abort count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gptp_tx_sched;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 80;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_vaild;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    resp_vaild;
    logic [DW-1:0]   resp_data;
    logic            resp_timeout;
    logic [AW-1:0]   send_addr;
    logic            send_vaild;
    logic            send_ready;
    logic [DW-1:0]   send_data;
    logic            send_r_vaild;
    logic [DW-1:0]   send_r_data;
    logic            busy;
    logic [7:0]      timeout_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_last;
    int m_tcnt;

    gptp_tx_sched #(
        .N       (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_vaild    (req_vaild),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .resp_vaild   (resp_vaild),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .send_addr    (send_addr),
        .send_vaild   (send_vaild),
        .send_ready   (send_ready),
        .send_data    (send_data),
        .send_r_vaild (send_r_vaild),
        .send_r_data  (send_r_data),
        .busy         (busy),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Scan last+1, last+2, ... mod N for the first active request.
    function automatic int pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic new_payloads();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'($urandom);
            req_data[i*DW +: DW] = rnd80();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},  DW'(req_ready),    '0);
        chk({tag, "_svld"},   DW'(send_vaild),   '0);
        chk({tag, "_saddr"},  DW'(send_addr),    '0);
        chk({tag, "_sdata"},  send_data,         '0);
        chk({tag, "_busy"},   DW'(busy),         '0);
        chk({tag, "_rvld"},   DW'(resp_vaild),   '0);
        chk({tag, "_rdata"},  resp_data,         '0);
        chk({tag, "_rto"},    DW'(resp_timeout), '0);
        chk({tag, "_tcnt"},   DW'(timeout_cnt),  '0);
    endtask

    // One complete transaction, entered in an IDLE cycle with payloads set.
    task automatic txn(input logic [N-1:0] mask, input int stall, input int wb_delay,
                       input bit to, input logic [DW-1:0] wb);
        int            g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req_vaild    = mask;
        send_ready   = 1'b0;
        send_r_vaild = 1'($urandom_range(0, 1));   // stray write-back in IDLE
        send_r_data  = rnd80();
        g = pick(mask, m_last);
        #1;
        chk("grant", DW'(req_ready), DW'(N'(1) << g));
        a = req_addr[g*AW +: AW];
        d = req_data[g*DW +: DW];
        m_last = g;

        step();
        send_r_vaild = 1'b0;
        chk("issue_vld",   DW'(send_vaild), DW'(1'b1));
        chk("issue_addr",  DW'(send_addr),  DW'(a));
        chk("issue_data",  send_data,       d);
        chk("issue_busy",  DW'(busy),       DW'(1'b1));
        chk("issue_ready", DW'(req_ready),  '0);
        chk("resp_clear",  DW'(resp_vaild), '0);

        for (int s = 0; s < stall; s++) begin
            send_ready   = 1'b0;
            send_r_vaild = 1'($urandom_range(0, 1));   // must be dropped
            send_r_data  = rnd80();
            step();
            chk("stall_vld",   DW'(send_vaild), DW'(1'b1));
            chk("stall_addr",  DW'(send_addr),  DW'(a));
            chk("stall_data",  send_data,       d);
            chk("stall_ready", DW'(req_ready),  '0);
            chk("stall_resp",  DW'(resp_vaild), '0);
        end

        send_ready   = 1'b1;
        send_r_vaild = 1'b0;
        step();
        send_ready = 1'b0;
        chk("wait_vld",  DW'(send_vaild), '0);
        chk("wait_busy", DW'(busy),       DW'(1'b1));

        if (to) begin
            for (int c = 0; c < TO - 1; c++) step();
            chk("to_pre_resp", DW'(resp_vaild), '0);
            chk("to_pre_busy", DW'(busy),       DW'(1'b1));
            step();
            m_tcnt = (m_tcnt < 255) ? m_tcnt + 1 : 255;
            chk("to_resp",  DW'(resp_vaild),   DW'(N'(1) << g));
            chk("to_flag",  DW'(resp_timeout), DW'(1'b1));
            chk("to_data",  resp_data,         '0);
            chk("to_busy",  DW'(busy),         '0);
            chk("to_cnt",   DW'(timeout_cnt),  DW'(m_tcnt));
        end else begin
            for (int c = 0; c < wb_delay; c++) step();
            send_r_vaild = 1'b1;
            send_r_data  = wb;
            step();
            send_r_vaild = 1'b0;
            chk("wb_resp", DW'(resp_vaild),   DW'(N'(1) << g));
            chk("wb_data", resp_data,         wb);
            chk("wb_flag", DW'(resp_timeout), '0);
            chk("wb_busy", DW'(busy),         '0);
            chk("wb_cnt",  DW'(timeout_cnt),  DW'(m_tcnt));
        end
    endtask

    initial begin
        reset        = 1'b0;
        req_vaild    = '1;
        req_addr     = '0;
        req_data     = '0;
        send_ready   = 1'b0;
        send_r_vaild = 1'b0;
        send_r_data  = '0;
        m_last       = N - 1;
        m_tcnt       = 0;

        // Reset state, with every requester asking.
        step();
        step();
        check_all_zero("rst");
        reset = 1'b1;

        // Fairness: all requesting, expect 0,1,2,3,0,1.
        for (int k = 0; k < 6; k++) begin
            new_payloads();
            txn('1, 0, 1, 1'b0, rnd80());
        end

        // Directed single request from requester 1.
        new_payloads();
        req_addr[1*AW +: AW] = 8'h01;
        req_data[1*DW +: DW] = 80'h123456789abc00000010;
        txn(4'b0010, 0, 2, 1'b0, 80'h123456789abc00000020);

        // send_ready stalled for 10 cycles.
        new_payloads();
        txn(4'b1001, 10, 3, 1'b0, rnd80());

        // Watchdog abort.
        new_payloads();
        txn(4'b0100, 1, 0, 1'b1, '0);

        // Write-back on the terminal timer cycle wins over the abort.
        new_payloads();
        txn(4'b1000, 0, TO - 1, 1'b0, rnd80());

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            new_payloads();
            txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
                $urandom_range(0, TO - 1), ($urandom_range(0, 3) == 0), rnd80());
        end

        // Drive the abort counter into saturation.
        for (int k = 0; k < 260; k++) begin
            new_payloads();
            txn(N'($urandom_range(1, (1 << N) - 1)), 0, 0, 1'b1, '0);
        end

        // Reset while waiting for a write-back.
        new_payloads();
        req_vaild = 4'b0100;
        step();
        send_ready = 1'b1;
        step();
        send_ready = 1'b0;
        req_vaild  = '1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        m_last = N - 1;
        m_tcnt = 0;
        step();
        reset = 1'b1;
        new_payloads();
        txn('1, 0, 4, 1'b0, rnd80());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
